// File: rtl/lpn_row_sel_ctrl.sv
// LPN row selector sequencer: loads the index, paces matrix-A rows,
// then drives the per-batch column shift-out into the multiplier.
module lpn_row_sel_ctrl #(
  parameter int N_ROWS = 450,
  parameter int BATCH  = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              two_batch,
  input  logic [N_ROWS-1:0] index_in,
  input  logic              row_valid,
  output logic              row_ready,
  output logic              sel_index_valid,
  output logic [N_ROWS-1:0] sel_index,
  output logic [8:0]        sel_number,
  output logic              sel_en,
  input  logic              sel_done,
  input  logic              mul_ready,
  output logic              sel_shift_en,
  output logic              batch_done,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SELECT,
    S_SHIFT,
    S_BATCH,
    S_FINISH
  } state_t;

  localparam logic [8:0] ROW_END    = 9'(N_ROWS);
  localparam logic [7:0] SHIFT_LAST = 8'(BATCH - 1);
  localparam logic [8:0] NUM_ONE    = 9'(BATCH);
  localparam logic [8:0] NUM_TWO    = 9'(2 * BATCH);

  state_t     state;
  state_t     state_n;
  logic       two_batch_r;
  logic       batch_idx;
  logic       armed;
  logic [8:0] row_cnt;
  logic [7:0] shift_cnt;
  logic       hit;
  logic       exhaust;

  // A sel_done only counts once the selector has been seen below target
  assign hit     = sel_done & armed;
  assign exhaust = (state == S_SELECT) & ~hit & (row_cnt == ROW_END);
  assign sel_en  = row_valid & row_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:   if (start) state_n = S_LOAD;
      S_LOAD:   state_n = S_SELECT;
      S_SELECT: begin
        if (hit)                     state_n = S_SHIFT;
        else if (row_cnt == ROW_END) state_n = S_IDLE;
      end
      S_SHIFT: begin
        if (mul_ready && shift_cnt == SHIFT_LAST)
          state_n = S_BATCH;
      end
      S_BATCH: begin
        if (two_batch_r && !batch_idx) state_n = S_SELECT;
        else                           state_n = S_FINISH;
      end
      S_FINISH: state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_comb begin
    sel_index_valid = 1'b0;
    row_ready       = 1'b0;
    sel_shift_en    = 1'b0;
    batch_done      = 1'b0;
    done            = 1'b0;
    busy            = (state != S_IDLE);
    unique case (state)
      S_LOAD:   sel_index_valid = 1'b1;
      S_SELECT: begin
        row_ready = ~hit & (row_cnt < ROW_END);
        done      = exhaust;
      end
      S_SHIFT:  sel_shift_en = mul_ready;
      S_BATCH:  batch_done = 1'b1;
      S_FINISH: done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_index   <= '0;
      sel_number  <= '0;
      two_batch_r <= 1'b0;
      err         <= 1'b0;
      row_cnt     <= '0;
      batch_idx   <= 1'b0;
      shift_cnt   <= '0;
      armed       <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        sel_index   <= index_in;
        two_batch_r <= two_batch;
        sel_number  <= two_batch ? NUM_TWO : NUM_ONE;
        err         <= 1'b0;
      end
      if (state == S_LOAD) begin
        row_cnt   <= '0;
        batch_idx <= 1'b0;
      end else if (sel_en) begin
        row_cnt <= row_cnt + 9'd1;
      end
      if (state == S_SELECT)  shift_cnt <= '0;
      else if (sel_shift_en)  shift_cnt <= shift_cnt + 8'd1;
      if (state != S_SELECT && state_n == S_SELECT) armed <= 1'b0;
      else if (state == S_SELECT && !sel_done)      armed <= 1'b1;
      if (exhaust) err <= 1'b1;
      if (state == S_BATCH && two_batch_r && !batch_idx)
        batch_idx <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lpn_row_sel_ctrl.sv
// Scoreboard bench for lpn_row_sel_ctrl with a behavioural selector
// stand-in and a row-index reference model.
module tb_lpn_row_sel_ctrl;
  localparam int N = 450;
  localparam int B = 128;

  logic         clk = 1'b0;
  logic         reset, start, two_batch;
  logic [N-1:0] index_in;
  logic         row_valid, row_ready, sel_index_valid;
  logic [N-1:0] sel_index;
  logic [8:0]   sel_number;
  logic         sel_en, sel_done, mul_ready, sel_shift_en;
  logic         batch_done, busy, done, err;

  lpn_row_sel_ctrl #(.N_ROWS(N), .BATCH(B)) dut (
    .clk(clk), .reset(reset), .start(start), .two_batch(two_batch),
    .index_in(index_in), .row_valid(row_valid), .row_ready(row_ready),
    .sel_index_valid(sel_index_valid), .sel_index(sel_index),
    .sel_number(sel_number), .sel_en(sel_en), .sel_done(sel_done),
    .mul_ready(mul_ready), .sel_shift_en(sel_shift_en),
    .batch_done(batch_done), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // selector stand-in: counts selected rows, flags 128 / 256
  logic [N-1:0] sidx;
  int           scnt, sptr;
  assign sel_done = (scnt == B) || (scnt == 2 * B);
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      scnt <= 0;
      sptr <= 0;
    end else if (sel_index_valid) begin
      sidx <= sel_index;
      scnt <= 0;
      sptr <= 0;
    end else if (sel_en) begin
      if (sidx[N-1-sptr]) scnt <= scnt + 1;
      sptr <= sptr + 1;
    end
  end

  typedef struct {
    bit is_done;
    bit err;
    int val;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   nerr = 0;
  int   nchk = 0;
  int   xfer = 0, shifts = 0, viol = 0, ndone = 0;
  bit   err_pend = 0, err_exp = 0;
  int   rv_mode = 0, mr_mode = 0;

  task automatic chk(input string name, input int act, input int req);
    nchk++;
    if (act != req) begin
      nerr++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  task automatic flag(input string name);
    nchk++;
    nerr++;
    $display("FAIL %s: got event, want none", name);
  endtask

  initial begin
    row_valid = 1'b0;
    mul_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rv_mode)
        0:       row_valid = 1'b1;
        1:       row_valid = ~row_valid;
        default: row_valid = ($urandom & 1) != 0;
      endcase
      case (mr_mode)
        0:       mul_ready = 1'b1;
        1:       mul_ready = ~mul_ready;
        default: mul_ready = ($urandom & 1) != 0;
      endcase
    end
  end

  // monitor: pops an expectation at every batch_done / done
  always @(negedge clk) begin
    if (reset) begin
      xfer = 0; shifts = 0; viol = 0; err_pend = 0;
    end else begin
      if (err_pend) begin
        chk("err_flag", int'(err), int'(err_exp));
        err_pend = 0;
      end
      if (sel_en) xfer++;
      if (sel_shift_en) shifts++;
      if (sel_en && !row_valid) viol++;
      if (sel_shift_en && !mul_ready) viol++;
      if (sel_en && sel_shift_en) viol++;
      if (batch_done) begin
        if (q.size() == 0) flag("unexpected_batch_done");
        else begin
          me = q.pop_front();
          chk("batch_not_end", int'(me.is_done), 0);
          chk("batch_shifts", shifts, me.val);
        end
        shifts = 0;
      end
      if (done) begin
        ndone++;
        if (q.size() == 0) flag("unexpected_done");
        else begin
          me = q.pop_front();
          chk("done_is_end", int'(me.is_done), 1);
          chk("transfers", xfer, me.val);
          chk("stray_shifts", shifts, 0);
          chk("protocol_viol", viol, 0);
          err_pend = 1;
          err_exp  = me.err;
        end
        xfer = 0; shifts = 0; viol = 0;
      end
    end
  end

  // walk the index MSB-first counting selected rows
  function automatic void ref_run(input logic [N-1:0] idx, input bit tb2,
                                  output int nb, output bit e, output int nx);
    int target;
    int ones;
    target = tb2 ? 2 * B : B;
    ones = 0; nb = 0; e = 1; nx = N;
    for (int r = 0; r < N; r++) begin
      if (idx[N-1-r]) begin
        ones++;
        if (ones % B == 0) nb++;
        if (ones == target) begin
          nx = r + 1;
          e  = 0;
          break;
        end
      end
    end
  endfunction

  function automatic logic [N-1:0] idx_contig();
    logic [N-1:0] v = '0;
    for (int r = 0; r < B; r++) v[N-1-r] = 1'b1;
    return v;
  endfunction

  function automatic logic [N-1:0] idx_sparse();
    logic [N-1:0] v = '0;
    for (int r = 258; r < N; r++)
      if ((r - 258) % 3 != 2) v[N-1-r] = 1'b1;
    return v;
  endfunction

  function automatic logic [N-1:0] idx_rand(input int k, input int lo);
    logic [N-1:0] v = '0;
    int c = 0;
    int p;
    while (c < k) begin
      p = int'($urandom_range(N - 1, lo));
      if (!v[p]) begin
        v[p] = 1'b1;
        c++;
      end
    end
    return v;
  endfunction

  task automatic expect_run(input logic [N-1:0] idx, input bit tb2);
    int nb, nx;
    bit e;
    ref_run(idx, tb2, nb, e, nx);
    for (int b = 0; b < nb; b++) q.push_back('{1'b0, 1'b0, B});
    q.push_back('{1'b1, e, nx});
  endtask

  task automatic kick(input logic [N-1:0] idx, input bit tb2,
                      input int rm, input int mm);
    @(posedge clk);
    #1;
    rv_mode = rm; mr_mode = mm;
    index_in = idx; two_batch = tb2; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; index_in = ~idx; two_batch = ~tb2;
  endtask

  task automatic run(input logic [N-1:0] idx, input bit tb2, input int rm,
                     input int mm, input bit lat_chk, input bit poke);
    int lat = 0;
    expect_run(idx, tb2);
    kick(idx, tb2, rm, mm);
    for (int n = 1; n <= 4000; n++) begin
      @(negedge clk);
      start = (poke && n == 20);
      if (done) begin
        lat = n;
        break;
      end
    end
    start = 1'b0;
    if (lat == 0) begin
      nchk++; nerr++;
      $display("FAIL run_timeout: got no done in 4000 cycles, want done");
      q.delete();
      @(posedge clk); #1; reset = 1'b1;
      @(posedge clk); #1; reset = 1'b0;
    end else if (lat_chk) begin
      // LOAD + 128 rows + sel_done cycle + 128 shifts + BATCH + FINISH
      chk("done_latency", lat, 1 + B + 1 + B + 1 + 1);
    end
    @(posedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    chk("idle_after_run", int'(busy), 0);
  endtask

  initial begin
    int d0;
    bit hit;
    reset = 1'b1; start = 1'b0; two_batch = 1'b0; index_in = '0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", int'(|{row_ready, sel_index_valid, sel_index,
        sel_number, sel_en, sel_shift_en, batch_done, busy, done, err}), 0);
    @(posedge clk); #1; reset = 1'b0;

    run(idx_contig(), 1'b0, 0, 0, 1'b1, 1'b0);
    run(idx_sparse(), 1'b0, 0, 0, 1'b0, 1'b0);
    run(idx_rand(2 * B, 0), 1'b1, 0, 0, 1'b0, 1'b0);
    run(idx_rand(100, 0), 1'b0, 0, 0, 1'b0, 1'b0);
    run(idx_contig(), 1'b0, 1, 1, 1'b0, 1'b0);
    begin
      logic [N-1:0] v = idx_rand(B - 1, 1);
      v[0] = 1'b1;
      run(v, 1'b0, 0, 0, 1'b0, 1'b0);
    end

    // abort mid-shift
    expect_run(idx_contig(), 1'b0);
    kick(idx_contig(), 1'b0, 0, 0);
    hit = 0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (shifts >= 50) begin
        hit = 1;
        break;
      end
    end
    chk("reached_50_shifts", int'(hit), 1);
    @(posedge clk); #1; reset = 1'b1; q.delete();
    @(negedge clk);
    chk("abort_outputs", int'(|{row_ready, sel_index_valid, sel_index,
        sel_number, sel_en, sel_shift_en, batch_done, busy, done, err}), 0);
    @(posedge clk); #1; reset = 1'b0;
    d0 = ndone;
    repeat (300) @(negedge clk);
    chk("no_done_after_abort", ndone - d0, 0);
    run(idx_contig(), 1'b0, 0, 0, 1'b1, 1'b0);

    for (int i = 0; i < 4; i++) begin
      run(idx_rand(int'($urandom_range(300, 90)), 0), ($urandom & 1) != 0,
          int'($urandom_range(2, 0)), int'($urandom_range(2, 0)),
          1'b0, 1'b1);
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
